// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 frame) and the motion controller state encoding.
package vga_pkg;

  localparam int H_VA    = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_LINE  = H_VA + H_FP + H_SYNC + H_BP;

  localparam int V_VA    = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_FRAME = V_VA + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_CFG  = 2'd1,
    ST_MOVE = 2'd2
  } state_t;

endpackage : vga_pkg

// File: rtl/square_motion_ctrl_if.sv
// Position-load handshake: the requester holds cfg_valid and the coordinates until cfg_ready.
interface square_motion_ctrl_if;

  logic       cfg_valid;
  logic [9:0] cfg_x;
  logic [8:0] cfg_y;
  logic       cfg_ready;

  modport master (output cfg_valid, cfg_x, cfg_y, input cfg_ready);
  modport slave  (input cfg_valid, cfg_x, cfg_y, output cfg_ready);

endinterface : square_motion_ctrl_if

// File: rtl/square_axis_step.sv
// Next position/direction for one axis of the bouncing square; clamps at 0 and at limit.
module square_axis_step #(
  parameter int W    = 10,
  parameter int STEP = 2
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  input  logic [W-1:0] limit,
  output logic [W-1:0] next_pos,
  output logic         next_dir
);

  // 11-bit intermediates so pos+STEP can never wrap before the limit compare.
  logic [10:0] pos_w;
  logic [10:0] lim_w;
  logic [10:0] step_w;
  logic [10:0] sum_w;
  logic [10:0] diff_w;

  assign pos_w  = 11'(pos);
  assign lim_w  = 11'(limit);
  assign step_w = 11'(STEP);
  assign sum_w  = pos_w + step_w;
  assign diff_w = pos_w - step_w;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    next_pos = pos;
    next_dir = dir;
    if (!dir) begin
      if (sum_w >= lim_w) begin
        next_pos = limit;
        next_dir = 1'b1;
      end else begin
        next_pos = W'(sum_w);
      end
    end else begin
      if (pos_w <= step_w) begin
        next_pos = '0;
        next_dir = 1'b0;
      end else begin
        next_pos = W'(diff_w);
      end
    end
  end

endmodule : square_axis_step

// File: rtl/square_motion_ctrl.sv
// Bouncing-square controller: moves or reloads the square once per frame during vertical blank
// and produces a registered per-pixel hit signal.
module square_motion_ctrl
  import vga_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int STEP = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [9:0]           h_count,
  input  logic [8:0]           v_count,
  input  logic                 display_on,
  input  logic                 en,
  square_motion_ctrl_if.slave  cfg,
  output logic [9:0]           sq_x,
  output logic [8:0]           sq_y,
  output logic                 dir_x,
  output logic                 dir_y,
  output logic                 frame_tick,
  output logic                 pixel_on
);

  localparam logic [9:0] X_LIM = 10'(H_VA - SIZE);
  localparam logic [8:0] Y_LIM = 9'(V_VA - SIZE);

  state_t     state;
  logic       cfg_ready;
  logic       frame_event;
  logic [9:0] nx_pos;
  logic [8:0] ny_pos;
  logic       nx_dir;
  logic       ny_dir;
  logic [9:0] clamp_x;
  logic [8:0] clamp_y;
  logic       hit;

  assign cfg.cfg_ready = cfg_ready;

  // Line 480, pixel 0 is the first blanking cycle after the last visible line.
  assign frame_event = (h_count == 10'd0) && (v_count == 9'(V_VA));

  assign clamp_x = (cfg.cfg_x > X_LIM) ? X_LIM : cfg.cfg_x;
  assign clamp_y = (cfg.cfg_y > Y_LIM) ? Y_LIM : cfg.cfg_y;

  square_axis_step #(.W(10), .STEP(STEP)) u_step_x (
    .pos      (sq_x),
    .dir      (dir_x),
    .limit    (X_LIM),
    .next_pos (nx_pos),
    .next_dir (nx_dir)
  );

  square_axis_step #(.W(9), .STEP(STEP)) u_step_y (
    .pos      (sq_y),
    .dir      (dir_y),
    .limit    (Y_LIM),
    .next_pos (ny_pos),
    .next_dir (ny_dir)
  );

  // Half-open window compare, widened so sq+SIZE cannot wrap.
  logic [10:0] hx, sx, vy, sy;
  assign hx = {1'b0, h_count};
  assign sx = {1'b0, sq_x};
  assign vy = {2'b00, v_count};
  assign sy = {2'b00, sq_y};

  assign hit = display_on
            && (hx >= sx) && (hx < sx + 11'(SIZE))
            && (vy >= sy) && (vy < sy + 11'(SIZE));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_RUN;
      sq_x       <= '0;
      sq_y       <= '0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      cfg_ready  <= 1'b0;
      frame_tick <= 1'b0;
      pixel_on   <= 1'b0;
    end else begin
      frame_tick <= frame_event;
      pixel_on   <= hit;
      cfg_ready  <= 1'b0;
      case (state)
        ST_RUN: begin
          if (frame_event) begin
            if (cfg.cfg_valid) begin
              state     <= ST_CFG;
              cfg_ready <= 1'b1;
            end else if (en) begin
              state <= ST_MOVE;
            end
          end
        end
        ST_CFG: begin
          sq_x  <= clamp_x;
          sq_y  <= clamp_y;
          state <= ST_RUN;
        end
        ST_MOVE: begin
          sq_x  <= nx_pos;
          sq_y  <= ny_pos;
          dir_x <= nx_dir;
          dir_y <= ny_dir;
          state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule : square_motion_ctrl

// File: tb/tb_square_motion_ctrl.sv
// Directed, table-driven bench for square_motion_ctrl; one table row is one frame.
module tb_square_motion_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [9:0] h_count;
  logic [8:0] v_count;
  logic       display_on;
  logic       en;
  logic [9:0] sq_x;
  logic [8:0] sq_y;
  logic       dir_x;
  logic       dir_y;
  logic       frame_tick;
  logic       pixel_on;

  square_motion_ctrl_if cfg_bus ();

  square_motion_ctrl #(.SIZE(32), .STEP(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .h_count    (h_count),
    .v_count    (v_count),
    .display_on (display_on),
    .en         (en),
    .cfg        (cfg_bus),
    .sq_x       (sq_x),
    .sq_y       (sq_y),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .frame_tick (frame_tick),
    .pixel_on   (pixel_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       valid;
    logic [9:0] cx;
    logic [8:0] cy;
    logic [9:0] ex;
    logic [8:0] ey;
    logic       edx;
    logic       edy;
    int         erdy;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   tick_cnt;
  int   rdy_cnt;
  logic auto_drop = 1'b1;
  vec_t vecs[15];

  function automatic vec_t mk(logic e, logic v, int cx, int cy, int ex, int ey,
                              logic dx, logic dy, int rdy);
    vec_t r;
    r.en = e; r.valid = v; r.cx = 10'(cx); r.cy = 9'(cy);
    r.ex = 10'(ex); r.ey = 9'(ey); r.edx = dx; r.edy = dy; r.erdy = rdy;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_idle();
    h_count    = 10'd1;
    v_count    = 9'd490;
    display_on = 1'b0;
  endtask

  // Called at each negedge: tally pulses and release the request once accepted.
  task automatic sample();
    if (frame_tick) tick_cnt++;
    if (cfg_bus.cfg_ready) begin
      rdy_cnt++;
      if (auto_drop) cfg_bus.cfg_valid = 1'b0;
    end
  endtask

  // Five blanking cycles, the frame event, then four cycles for the update to settle.
  task automatic run_frame(input logic e, input logic v, input logic [9:0] cx, input logic [8:0] cy);
    tick_cnt = 0;
    rdy_cnt  = 0;
    en = e;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_x = cx;
    cfg_bus.cfg_y = cy;
    repeat (5) begin
      @(negedge clk);
      sample();
    end
    h_count = 10'd0;
    v_count = 9'd480;
    @(negedge clk);
    set_idle();
    sample();
    repeat (3) begin
      @(negedge clk);
      sample();
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey, input logic dx, input logic dy);
    check({tag, ".sq_x"},  int'(sq_x),  ex);
    check({tag, ".sq_y"},  int'(sq_y),  ey);
    check({tag, ".dir_x"}, int'(dir_x), int'(dx));
    check({tag, ".dir_y"}, int'(dir_y), int'(dy));
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic d, input logic exp);
    @(negedge clk);
    h_count = 10'(h);
    v_count = 9'(v);
    display_on = d;
    @(negedge clk);
    check(tag, int'(pixel_on), int'(exp));
  endtask

  initial begin
    vecs[0]  = mk(1, 0,   0,   0,   2,   2, 0, 0, 0);
    vecs[1]  = mk(1, 0,   0,   0,   4,   4, 0, 0, 0);
    vecs[2]  = mk(1, 1, 607,   0, 607,   0, 0, 0, 1);
    vecs[3]  = mk(1, 0,   0,   0, 608,   2, 1, 0, 0);
    vecs[4]  = mk(1, 0,   0,   0, 606,   4, 1, 0, 0);
    vecs[5]  = mk(1, 1, 700, 500, 608, 448, 1, 0, 1);
    vecs[6]  = mk(0, 0,   0,   0, 608, 448, 1, 0, 0);
    vecs[7]  = mk(0, 0,   0,   0, 608, 448, 1, 0, 0);
    vecs[8]  = mk(0, 0,   0,   0, 608, 448, 1, 0, 0);
    vecs[9]  = mk(1, 0,   0,   0, 606, 448, 1, 1, 0);
    vecs[10] = mk(1, 0,   0,   0, 604, 446, 1, 1, 0);
    vecs[11] = mk(0, 1,   1,   1,   1,   1, 1, 1, 1);
    vecs[12] = mk(1, 0,   0,   0,   0,   0, 0, 0, 0);
    vecs[13] = mk(1, 0,   0,   0,   2,   2, 0, 0, 0);
    vecs[14] = mk(0, 1, 100,  50, 100,  50, 0, 0, 1);

    rstn = 1'b0;
    en = 1'b1;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_x = '0;
    cfg_bus.cfg_y = '0;
    set_idle();
    repeat (3) @(negedge clk);
    check_pos("reset", 0, 0, 1'b0, 1'b0);
    check("reset.frame_tick", int'(frame_tick), 0);
    check("reset.cfg_ready", int'(cfg_bus.cfg_ready), 0);
    check("reset.pixel_on", int'(pixel_on), 0);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_frame(vecs[i].en, vecs[i].valid, vecs[i].cx, vecs[i].cy);
      check_pos(tag, int'(vecs[i].ex), int'(vecs[i].ey), vecs[i].edx, vecs[i].edy);
      check({tag, ".ticks"}, tick_cnt, 1);
      check({tag, ".ready_pulses"}, rdy_cnt, vecs[i].erdy);
    end

    // Square at (100,50): window is [100,132) x [50,82).
    pix("pix.corner_in",  100, 50, 1'b1, 1'b1);
    pix("pix.right_in",   131, 60, 1'b1, 1'b1);
    pix("pix.right_out",  132, 60, 1'b1, 1'b0);
    pix("pix.left_out",    99, 60, 1'b1, 1'b0);
    pix("pix.bottom_in",  120, 81, 1'b1, 1'b1);
    pix("pix.bottom_out", 100, 82, 1'b1, 1'b0);
    pix("pix.top_out",    110, 49, 1'b1, 1'b0);
    pix("pix.blanked",    100, 50, 1'b0, 1'b0);
    check_pos("visible_hold", 100, 50, 1'b0, 1'b0);

    // Request withdrawn before the frame event: nothing loads.
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_x = 10'd300;
    cfg_bus.cfg_y = 9'd200;
    repeat (3) @(negedge clk);
    run_frame(1'b0, 1'b0, 10'd300, 9'd200);
    check_pos("withdrawn", 100, 50, 1'b0, 1'b0);
    check("withdrawn.ready_pulses", rdy_cnt, 0);

    // Held request reloads on every frame and suppresses motion.
    auto_drop = 1'b0;
    run_frame(1'b1, 1'b1, 10'd10, 9'd20);
    check_pos("held1", 10, 20, 1'b0, 1'b0);
    check("held1.ready_pulses", rdy_cnt, 1);
    run_frame(1'b1, 1'b1, 10'd10, 9'd20);
    check_pos("held2", 10, 20, 1'b0, 1'b0);
    check("held2.ready_pulses", rdy_cnt, 1);

    // Reset asserted while in CFG; the held request completes on the next frame.
    cfg_bus.cfg_x = 10'd50;
    cfg_bus.cfg_y = 9'd60;
    @(negedge clk);
    h_count = 10'd0;
    v_count = 9'd480;
    @(negedge clk);
    set_idle();
    check("midcfg.cfg_ready", int'(cfg_bus.cfg_ready), 1);
    #1 rstn = 1'b0;
    #1;
    check_pos("midrst", 0, 0, 1'b0, 1'b0);
    check("midrst.cfg_ready", int'(cfg_bus.cfg_ready), 0);
    check("midrst.frame_tick", int'(frame_tick), 0);
    check("midrst.pixel_on", int'(pixel_on), 0);
    @(negedge clk);
    check_pos("midrst.held", 0, 0, 1'b0, 1'b0);
    rstn = 1'b1;
    auto_drop = 1'b1;
    run_frame(1'b1, 1'b1, 10'd50, 9'd60);
    check_pos("retry", 50, 60, 1'b0, 1'b0);
    check("retry.ready_pulses", rdy_cnt, 1);
    check("retry.valid_dropped", int'(cfg_bus.cfg_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_square_motion_ctrl

// File: doc/square_motion_ctrl.md
SQUARE_MOTION_CTRL -- requirements
Module: square_motion_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, meaning the square edge length in pixels.
REQ-002 The block SHALL have parameter STEP, default 2, meaning the pixels moved per frame on each axis.
REQ-003 The block SHALL have port clk, input, 1, meaning the pixel clock; it is the only clock.
REQ-004 The block SHALL have port rstn, input, 1, meaning the reset; reset is asynchronous and active-low.
REQ-005 The block SHALL have port h_count, input, 10, meaning the horizontal pixel counter from the sync generator.
REQ-006 The block SHALL have port v_count, input, 9, meaning the vertical line counter from the sync generator.
REQ-007 The block SHALL have port display_on, input, 1, meaning that the current pixel lies in the visible area.
REQ-008 The block SHALL have port en, input, 1, meaning that motion is enabled.
REQ-009 The block SHALL have port cfg_valid, input, 1, meaning that a position load is requested; the requester holds it until cfg_ready.
REQ-010 The block SHALL have port cfg_x, input, 10, meaning the requested left edge.
REQ-011 The block SHALL have port cfg_y, input, 9, meaning the requested top edge.
REQ-012 The block SHALL have port cfg_ready, output, 1, meaning a one-cycle acceptance pulse.
REQ-013 The block SHALL have port sq_x, output, 10, meaning the current left edge.
REQ-014 The block SHALL have port sq_y, output, 9, meaning the current top edge.
REQ-015 The block SHALL have port dir_x, output, 1, meaning the horizontal direction: 0 is right, 1 is left.
REQ-016 The block SHALL have port dir_y, output, 1, meaning the vertical direction: 0 is down, 1 is up.
REQ-017 The block SHALL have port frame_tick, output, 1, meaning a one-cycle pulse per frame boundary.
REQ-018 The block SHALL have port pixel_on, output, 1, meaning the registered square-hit signal.

Function
REQ-019 The frame event SHALL be the cycle with h_count==0 and v_count==480; it occurs once per frame.
REQ-020 frame_tick SHALL assert in the cycle after each frame event.
REQ-021 FSM states SHALL be RUN, CFG and MOVE.
REQ-022 RUN SHALL go to CFG on a frame event when cfg_valid=1.
REQ-023 RUN SHALL go to MOVE on a frame event when cfg_valid=0 and en=1.
REQ-024 In all other cases RUN SHALL remain in RUN.
REQ-025 CFG SHALL last 1 cycle and then return to RUN.
- In CFG: load sq_x = min(cfg_x, 640-SIZE) and sq_y = min(cfg_y, 480-SIZE).
- In CFG: pulse cfg_ready; directions are unchanged; no motion occurs that frame.
REQ-026 MOVE SHALL last 1 cycle, update both axes, and return to RUN.
REQ-027 X axis, dir_x=0: if sq_x+STEP >= 640-SIZE then sq_x = 640-SIZE and dir_x flips to 1; otherwise sq_x += STEP.
REQ-028 X axis, dir_x=1: if sq_x <= STEP then sq_x = 0 and dir_x flips to 0; otherwise sq_x -= STEP.
REQ-029 The Y axis SHALL follow the same rules with limit 480-SIZE and dir_y.
REQ-030 Edge arithmetic SHALL use 11-bit intermediates; positions SHALL never exceed their limits or wrap.
REQ-031 pixel_on SHALL equal the registered value, one cycle of latency, of: display_on & (sq_x <= h_count < sq_x+SIZE) & (sq_y <= v_count < sq_y+SIZE).
REQ-032 sq_x, sq_y, dir_x and dir_y SHALL change only in CFG or MOVE, never during the visible area.
REQ-033 cfg_valid deasserted before a frame event SHALL cause no load and no cfg_ready.
REQ-034 At most one load SHALL occur per frame; a held cfg_valid reloads on each frame event.
REQ-035 en=0 SHALL freeze motion while CFG loads are still accepted.

Reset
REQ-036 When rstn=0, the block SHALL asynchronously set state=RUN, sq_x=0, sq_y=0, dir_x=0, dir_y=0, cfg_ready=0, frame_tick=0 and pixel_on=0.
REQ-037 On a reset mid-frame or mid-handshake, any pending request SHALL be dropped, and the requester keeps cfg_valid high to retry at the next frame event.

Structure
REQ-038 A shared package vga_pkg SHALL hold the constants H_VA=640 and V_VA=480, the porch, sync and whole-line constants, and the FSM state enum.
REQ-039 One sub-module, square_axis_step, SHALL compute the next position and direction for one axis from (pos, dir, limit, STEP); it SHALL be instantiated twice (X and Y).

Verification
REQ-040 Reset release with en=1 and SIZE=32, STEP=2: after frames 1 and 2, (sq_x,sq_y) SHALL read (2,2) then (4,4), and frame_tick SHALL pulse once per frame.
REQ-041 cfg_x=607, cfg_y=0, en=1: at the first frame event after the load, sq_x SHALL read 608 with dir_x=1; at the next frame event, sq_x SHALL read 606.
REQ-042 cfg_valid rising 5 cycles before a frame event with cfg_x=700, cfg_y=500: sq_x SHALL read 608, sq_y SHALL read 448, cfg_ready SHALL pulse exactly once, and no motion SHALL occur that frame.
REQ-043 en=0 for 3 frames: sq_x, sq_y, dir_x and dir_y SHALL hold constant, and frame_tick SHALL still pulse 3 times.
REQ-044 With sq=(100,50): pixel_on SHALL be 1 one cycle after h_count=100, v_count=50, and 0 after h_count=132 or v_count=82.
REQ-045 rstn low during CFG with cfg_valid held: all outputs SHALL reset; after release, the load SHALL complete at the next frame event.
